// File: rtl/quesadilla_fetch_ctrl_pkg.sv
// rtl/quesadilla_fetch_ctrl_pkg.sv - shared state encodings and defaults for the quesadilla fetch sequencer
//
// Holds the fetch FSM state encodings and the default reset PC, PC step and
// ack-timeout values. The fetch controller and its wait timer import these.

package quesadilla_fetch_ctrl_pkg;

  typedef logic [1:0] fetch_state_t;

  // Legacy-compatible encodings; external debug tooling decodes these values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_PC_STEP  = 4;
  localparam int          DEFAULT_TIMEOUT  = 15;

endpackage

// File: rtl/quesadilla_wait_timer.sv
// rtl/quesadilla_wait_timer.sv - saturating memory-ack timeout counter
//
// Counts request cycles that went by without an ack.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clr      in  zero the count (wins over inc)
//   inc      in  one more cycle without ack
//   expired  out this inc brings the count to TIMEOUT (never asserts when TIMEOUT=0)

module quesadilla_wait_timer
  import quesadilla_fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  // Saturates at LIMIT so a long stall in the error state can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Flagged in the same cycle as the increment that reaches TIMEOUT so the
  // FSM leaves FETCH after exactly TIMEOUT request cycles.
  assign expired = (TIMEOUT != 0) && inc && (count >= LAST);

endmodule

// File: rtl/quesadilla_fetch_ctrl.sv
// rtl/quesadilla_fetch_ctrl.sv - instruction-fetch sequencer: PC, imem handshake, decode handoff
//
// Owns the fetch PC, issues one level-sensitive memory request at a time and
// hands each returned word to decode through a valid/ready handshake.
// Ports:
//   clk_q, rst_q_n   clock, asynchronous active-low reset
//   en_q             fetch enable (a fetch already in flight always completes)
//   imem_req_q       memory request, high exactly while in FETCH
//   imem_addr_q      fetch address (current fetch PC)
//   imem_ack_q       memory ack, ignored when no request is out
//   imem_data_q      instruction word returned with the ack
//   instQ            instruction presented to decode
//   inst_valid_q     instQ valid
//   inst_ready_q     decode accepts instQ
//   pc_q             address of the word in instQ
//   redirect_q       branch/jump redirect strobe, highest priority in every state
//   redirect_pc_q    new fetch PC, used as-is
//   fetch_err_q      sticky ack-timeout error, cleared only by redirect or reset

module quesadilla_fetch_ctrl
  import quesadilla_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                PC_STEP  = DEFAULT_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic              clk_q,
  input  logic              rst_q_n,
  input  logic              en_q,
  output logic              imem_req_q,
  output logic [ADDR_W-1:0] imem_addr_q,
  input  logic              imem_ack_q,
  input  logic [DATA_W-1:0] imem_data_q,
  output logic [DATA_W-1:0] instQ,
  output logic              inst_valid_q,
  input  logic              inst_ready_q,
  output logic [ADDR_W-1:0] pc_q,
  input  logic              redirect_q,
  input  logic [ADDR_W-1:0] redirect_pc_q,
  output logic              fetch_err_q
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;

  logic in_fetch;
  logic in_hold;
  logic ack_take;
  logic beat_done;
  logic timer_clr;
  logic timer_inc;
  logic timer_expired;

  assign in_fetch = (state == ST_FETCH);
  assign in_hold  = (state == ST_HOLD);

  // An ack arriving together with a redirect belongs to the squashed path.
  assign ack_take  = in_fetch && imem_ack_q && !redirect_q;
  assign beat_done = in_hold && inst_ready_q;

  // Request follows state directly so the async reset drops it immediately.
  assign imem_req_q  = in_fetch;
  assign imem_addr_q = fetch_pc;

  assign timer_clr = redirect_q || ack_take;
  assign timer_inc = in_fetch && !imem_ack_q && !redirect_q;

  quesadilla_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk_q),
    .rst_n   (rst_q_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  always_comb begin
    state_nxt = state;
    if (redirect_q) begin
      state_nxt = en_q ? ST_FETCH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_q) state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          // en_q is deliberately not looked at: a started fetch always finishes.
          if (imem_ack_q)         state_nxt = ST_HOLD;
          else if (timer_expired) state_nxt = ST_ERR;
        end
        ST_HOLD: begin
          if (inst_ready_q) state_nxt = en_q ? ST_FETCH : ST_IDLE;
        end
        default: begin
          state_nxt = ST_ERR;
        end
      endcase
    end
  end

  always_ff @(posedge clk_q or negedge rst_q_n) begin
    if (!rst_q_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch PC: reloaded by redirect, advanced (mod 2^ADDR_W) on every accepted ack.
  always_ff @(posedge clk_q or negedge rst_q_n) begin
    if (!rst_q_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_q) begin
      fetch_pc <= redirect_pc_q;
    end else if (ack_take) begin
      fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
    end
  end

  // Decode-side output register. instQ/pc_q are only written on an accepted
  // ack, so they stay put through back-pressure and after a squash.
  always_ff @(posedge clk_q or negedge rst_q_n) begin
    if (!rst_q_n) begin
      instQ        <= '0;
      pc_q         <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      if (ack_take) begin
        instQ <= imem_data_q;
        pc_q  <= fetch_pc;
      end
      // A HOLD beat accepted in the redirect cycle has already transferred,
      // so clearing valid here never duplicates or loses it.
      if (redirect_q || beat_done) begin
        inst_valid_q <= 1'b0;
      end else if (ack_take) begin
        inst_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_q or negedge rst_q_n) begin
    if (!rst_q_n) begin
      fetch_err_q <= 1'b0;
    end else if (redirect_q) begin
      fetch_err_q <= 1'b0;
    end else if (in_fetch && !imem_ack_q && timer_expired) begin
      fetch_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quesadilla_fetch_ctrl.sv
// tb/tb_quesadilla_fetch_ctrl.sv - self-checking bench for quesadilla_fetch_ctrl

module tb_quesadilla_fetch_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk_q = 1'b0;
  logic        rst_q_n;
  logic        en_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        imem_ack_q;
  logic [31:0] imem_data_q;
  logic [31:0] instQ;
  logic        inst_valid_q;
  logic        inst_ready_q;
  logic [31:0] pc_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic        fetch_err_q;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int ack_delay = 0;
  bit ack_never = 1'b0;
  int wcnt;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    longint      t;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] ack_addrs[$];

  logic        m_req;
  logic [31:0] m_addr;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_err;
  int          m_wait;

  always #5 clk_q = ~clk_q;

  quesadilla_fetch_ctrl dut (
    .clk_q         (clk_q),
    .rst_q_n       (rst_q_n),
    .en_q          (en_q),
    .imem_req_q    (imem_req_q),
    .imem_addr_q   (imem_addr_q),
    .imem_ack_q    (imem_ack_q),
    .imem_data_q   (imem_data_q),
    .instQ         (instQ),
    .inst_valid_q  (inst_valid_q),
    .inst_ready_q  (inst_ready_q),
    .pc_q          (pc_q),
    .redirect_q    (redirect_q),
    .redirect_pc_q (redirect_pc_q),
    .fetch_err_q   (fetch_err_q)
  );

  // ROM: word at byte address a holds a/4. Ack after ack_delay waiting cycles.
  assign imem_data_q = {2'b00, imem_addr_q[31:2]};
  assign imem_ack_q  = imem_req_q && !ack_never && (wcnt >= ack_delay);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_q);
    #2;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(beats.size() >= n), 64'd1);
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int k = 0;
    while (ack_addrs.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(ack_addrs.size() >= n), 64'd1);
  endtask

  // Memory responder, transfer monitors and the reference model.
  always @(posedge clk_q or negedge rst_q_n) begin
    if (!rst_q_n) begin
      wcnt    <= 0;
      m_req   <= 1'b0;
      m_addr  <= 32'h0;
      m_valid <= 1'b0;
      m_inst  <= 32'h0;
      m_pc    <= 32'h0;
      m_err   <= 1'b0;
      m_wait  <= 0;
    end else begin
      wcnt <= (imem_req_q && !imem_ack_q && !redirect_q) ? wcnt + 1 : 0;
      if (inst_valid_q && inst_ready_q)
        beats.push_back('{inst: instQ, pc: pc_q, t: longint'($time)});
      if (imem_req_q && imem_ack_q && !redirect_q)
        ack_addrs.push_back(imem_addr_q);

      if (redirect_q) begin
        m_addr  <= redirect_pc_q;
        m_valid <= 1'b0;
        m_wait  <= 0;
        m_err   <= 1'b0;
        m_req   <= en_q;
      end else if (m_err) begin
        m_req <= 1'b0;
      end else if (m_valid) begin
        if (inst_ready_q) begin
          m_valid <= 1'b0;
          m_req   <= en_q;
        end
      end else if (m_req) begin
        if (imem_ack_q) begin
          m_inst  <= m_addr >> 2;
          m_pc    <= m_addr;
          m_addr  <= m_addr + 32'd4;
          m_valid <= 1'b1;
          m_req   <= 1'b0;
          m_wait  <= 0;
        end else if (m_wait + 1 >= TIMEOUT) begin
          m_err  <= 1'b1;
          m_req  <= 1'b0;
          m_wait <= m_wait + 1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        m_req <= en_q;
      end
    end
  end

  always @(negedge clk_q) begin
    if (cmp_en) begin
      chk("cmp_req",   64'(imem_req_q),   64'(m_req));
      chk("cmp_addr",  64'(imem_addr_q),  64'(m_addr));
      chk("cmp_valid", 64'(inst_valid_q), 64'(m_valid));
      chk("cmp_inst",  64'(instQ),        64'(m_inst));
      chk("cmp_pc",    64'(pc_q),         64'(m_pc));
      chk("cmp_err",   64'(fetch_err_q),  64'(m_err));
    end
  end

  initial begin
    int n;
    rst_q_n       = 1'b0;
    en_q          = 1'b0;
    inst_ready_q  = 1'b1;
    redirect_q    = 1'b0;
    redirect_pc_q = 32'h0;
    repeat (3) tick();
    cmp_en  = 1'b1;
    rst_q_n = 1'b1;
    tick();

    // 1: reset in the middle of a fetch
    ack_never = 1'b1;
    en_q      = 1'b1;
    tick();
    chk("t1_req_up", 64'(imem_req_q), 64'd1);
    tick();
    rst_q_n = 1'b0;
    #1;
    chk("t1_req_drop", 64'(imem_req_q),   64'd0);
    chk("t1_valid",    64'(inst_valid_q), 64'd0);
    chk("t1_pc",       64'(pc_q),         64'd0);
    chk("t1_err",      64'(fetch_err_q),  64'd0);
    chk("t1_addr",     64'(imem_addr_q),  64'd0);
    tick();
    ack_never = 1'b0;
    beats.delete();
    ack_addrs.delete();
    rst_q_n = 1'b1;

    // 2: zero-wait ROM streaming
    wait_beats(3, 30, "t2_beats");
    chk("t2_ack0", 64'(ack_addrs[0]), 64'h0);
    chk("t2_ack1", 64'(ack_addrs[1]), 64'h4);
    chk("t2_ack2", 64'(ack_addrs[2]), 64'h8);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_inst%0d", i), 64'(beats[i].inst), 64'(i));
      chk($sformatf("t2_pc%0d", i),   64'(beats[i].pc),   64'(4 * i));
    end
    chk("t2_rate01", 64'(beats[1].t - beats[0].t), 64'd20);
    chk("t2_rate12", 64'(beats[2].t - beats[1].t), 64'd20);

    // 3: back-pressure
    en_q = 1'b0;
    repeat (6) tick();
    redirect_q    = 1'b1;
    redirect_pc_q = 32'h200;
    tick();
    redirect_q = 1'b0;
    chk("t3_redir_addr", 64'(imem_addr_q), 64'h200);
    inst_ready_q = 1'b0;
    en_q         = 1'b1;
    beats.delete();
    ack_addrs.delete();
    n = 0;
    while (!inst_valid_q && n < 10) begin
      tick();
      n++;
    end
    chk("t3_valid_up", 64'(inst_valid_q), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 64'(inst_valid_q), 64'd1);
      chk("t3_hold_inst",  64'(instQ),        64'h80);
      chk("t3_hold_pc",    64'(pc_q),         64'h200);
      chk("t3_hold_req",   64'(imem_req_q),   64'd0);
      chk("t3_hold_addr",  64'(imem_addr_q),  64'h204);
    end
    inst_ready_q = 1'b1;
    wait_acks(2, 10, "t3_next_ack");
    chk("t3_ack_addr", 64'(ack_addrs[1]), 64'h204);
    chk("t3_beat_pc",  64'(beats[0].pc),  64'h200);

    // 4: redirect while waiting on a slow ack
    en_q = 1'b0;
    repeat (6) tick();
    ack_delay     = 3;
    redirect_q    = 1'b1;
    redirect_pc_q = 32'h300;
    tick();
    redirect_q = 1'b0;
    beats.delete();
    ack_addrs.delete();
    en_q = 1'b1;
    n = 0;
    while (!imem_req_q && n < 10) begin
      tick();
      n++;
    end
    chk("t4_req_up", 64'(imem_req_q), 64'd1);
    tick();
    redirect_q    = 1'b1;
    redirect_pc_q = 32'h100;
    tick();
    redirect_q = 1'b0;
    chk("t4_addr", 64'(imem_addr_q), 64'h100);
    wait_beats(1, 20, "t4_beats");
    chk("t4_beat_pc",   64'(beats[0].pc),   64'h100);
    chk("t4_beat_inst", 64'(beats[0].inst), 64'h40);
    chk("t4_ack0",      64'(ack_addrs[0]),  64'h100);

    // 5: ack timeout, then recovery by redirect
    ack_delay = 0;
    en_q      = 1'b0;
    repeat (6) tick();
    ack_never = 1'b1;
    en_q      = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_req_q) n++;
      if (fetch_err_q) break;
    end
    chk("t5_req_cycles", 64'(n),            64'd15);
    chk("t5_err",        64'(fetch_err_q),  64'd1);
    chk("t5_req_low",    64'(imem_req_q),   64'd0);
    repeat (3) tick();
    chk("t5_err_sticky", 64'(fetch_err_q),  64'd1);
    ack_never     = 1'b0;
    beats.delete();
    redirect_q    = 1'b1;
    redirect_pc_q = 32'h40;
    tick();
    redirect_q = 1'b0;
    chk("t5_err_clr", 64'(fetch_err_q), 64'd0);
    chk("t5_req",     64'(imem_req_q),  64'd1);
    chk("t5_addr",    64'(imem_addr_q), 64'h40);
    wait_beats(1, 10, "t5_beats");
    chk("t5_beat_pc",   64'(beats[0].pc),   64'h40);
    chk("t5_beat_inst", 64'(beats[0].inst), 64'h10);

    // 6: PC wrap at the top of the address space
    en_q = 1'b0;
    repeat (6) tick();
    redirect_q    = 1'b1;
    redirect_pc_q = 32'hFFFF_FFFC;
    en_q          = 1'b1;
    tick();
    redirect_q = 1'b0;
    beats.delete();
    ack_addrs.delete();
    wait_acks(2, 10, "t6_acks");
    chk("t6_ack0",      64'(ack_addrs[0]),  64'hFFFF_FFFC);
    chk("t6_ack1",      64'(ack_addrs[1]),  64'h0);
    chk("t6_beat_pc",   64'(beats[0].pc),   64'hFFFF_FFFC);
    chk("t6_beat_inst", 64'(beats[0].inst), 64'h3FFF_FFFF);

    en_q = 1'b0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
